// File: rtl/bus_arbiter_multi.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_multi
// Purpose  : Bootstrap and bus arbitration for the on-card 68SEC000.
//            After reset, the block waits BOOT_CYCLES clocks. It then probes
//            the host platform to decide whether DMA is allowed. When DMA is
//            allowed, it arbitrates NUM_REQ requesters for the CPU bus using
//            the full BR/BG/BGACK handshake:
//              - index 0 is the motherboard BR_n line;
//              - higher indices are on-card DMA engines.
//            A watchdog withdraws a grant that is never acknowledged.
// Ports    : C7M, RESET_n        - clock, async active-low reset
//            JP2, BOSS_n_IN,
//            BG_n_IN             - platform probe inputs
//            REQ_n / ACK_n       - per-requester request / BGACK (active-low)
//            AS_n, BG_CPU_n      - CPU bus status
//            BR_CPU_n,
//            BGACK_CPU_n         - handshake towards the CPU
//            GNT_n               - one-hot-low grants
//            BOSS_n_OUT/OE,
//            BR_n_OE, E_OE       - motherboard line drive controls
//            DMA_EN, OWNER,
//            TIMEOUT             - status
// Revision : 1.0  initial release
// ============================================================================
module bus_arbiter_multi #(
    parameter int NUM_REQ     = 2,
    parameter int BOOT_CYCLES = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int ROUND_ROBIN = 0
) (
    input  logic               C7M,
    input  logic               RESET_n,
    input  logic               JP2,
    input  logic               BOSS_n_IN,
    input  logic               BG_n_IN,
    input  logic [NUM_REQ-1:0] REQ_n,
    input  logic [NUM_REQ-1:0] ACK_n,
    input  logic               AS_n,
    input  logic               BG_CPU_n,
    output logic               BR_CPU_n,
    output logic               BGACK_CPU_n,
    output logic [NUM_REQ-1:0] GNT_n,
    output logic               BOSS_n_OUT,
    output logic               BOSS_n_OE,
    output logic               BR_n_OE,
    output logic               E_OE,
    output logic               DMA_EN,
    output logic [2:0]         OWNER,
    output logic               TIMEOUT
);

    typedef enum logic [2:0] {
        ST_BOOT_WAIT = 3'd0,
        ST_PROBE     = 3'd1,
        ST_DISABLED  = 3'd2,
        ST_IDLE      = 3'd3,
        ST_REQUEST   = 3'd4,
        ST_GRANT     = 3'd5,
        ST_OWNED     = 3'd6
    } state_t;

    localparam logic [7:0] c_boot_last = 8'(BOOT_CYCLES - 1);
    localparam logic [7:0] c_ack_last  = 8'(ACK_TIMEOUT - 1);
    localparam logic [2:0] c_last_idx  = 3'(NUM_REQ - 1);

    state_t             r_state;
    logic [7:0]         r_boot_cnt;
    logic [7:0]         r_wd_cnt;
    logic [2:0]         r_sel;
    logic [2:0]         r_rr;

    state_t             w_state;
    logic [7:0]         w_boot_cnt;
    logic [7:0]         w_wd_cnt;
    logic [2:0]         w_sel;
    logic [2:0]         w_rr;
    logic               w_br_cpu_n;
    logic               w_bgack_cpu_n;
    logic [NUM_REQ-1:0] w_gnt_n;
    logic               w_boss_n_out;
    logic               w_boss_n_oe;
    logic               w_br_n_oe;
    logic               w_e_oe;
    logic               w_dma_en;
    logic [2:0]         w_owner;
    logic               w_timeout;

    logic [2:0]         w_win;
    int                 w_best;
    int                 w_dist;
    logic [NUM_REQ-1:0] w_sel_mask;
    logic               w_sel_req;
    logic               w_sel_ack;
    logic [2:0]         w_sel_plus1;

    // The latched winner is turned into a one-hot mask, so that its request
    // and acknowledge can be picked out without a variable-width bit select.
    assign w_sel_mask  = NUM_REQ'(1) << r_sel;
    assign w_sel_req   = |(~REQ_n & w_sel_mask);
    assign w_sel_ack   = |(~ACK_n & w_sel_mask);
    assign w_sel_plus1 = (r_sel == c_last_idx) ? 3'd0 : r_sel + 3'd1;

    // Winner selection. Each asserted requester gets a distance:
    //   - fixed priority: its own index;
    //   - round-robin: its offset from the rotating pointer, modulo NUM_REQ.
    // The smallest distance wins.
    always_comb begin
        w_win  = 3'd0;
        w_best = NUM_REQ;
        w_dist = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (ROUND_ROBIN != 0) begin
                if (j >= int'(r_rr)) w_dist = j - int'(r_rr);
                else                 w_dist = j + NUM_REQ - int'(r_rr);
            end else begin
                w_dist = j;
            end
            if (!REQ_n[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = 3'(j);
            end
        end
    end

    // Next-state and next-output logic. Every output is registered, so each
    // next value defaults to its current value.
    always_comb begin
        w_state       = r_state;
        w_boot_cnt    = r_boot_cnt;
        w_wd_cnt      = r_wd_cnt;
        w_sel         = r_sel;
        w_rr          = r_rr;
        w_br_cpu_n    = BR_CPU_n;
        w_bgack_cpu_n = BGACK_CPU_n;
        w_gnt_n       = GNT_n;
        w_boss_n_out  = BOSS_n_OUT;
        w_boss_n_oe   = BOSS_n_OE;
        w_br_n_oe     = BR_n_OE;
        w_e_oe        = E_OE;
        w_dma_en      = DMA_EN;
        w_owner       = OWNER;
        w_timeout     = 1'b0;

        case (r_state)
            ST_BOOT_WAIT: begin
                if (r_boot_cnt == c_boot_last) w_state = ST_PROBE;
                else                           w_boot_cnt = r_boot_cnt + 8'd1;
            end

            ST_PROBE: begin
                // BG low without the E jumper means the socketed CPU has not
                // yet answered. Keep the card CPU parked and look again.
                if (!BG_n_IN && !JP2) begin
                    w_br_cpu_n = 1'b0;
                end else begin
                    w_br_cpu_n = 1'b1;
                    w_e_oe     = ~JP2;
                    if (BOSS_n_IN) begin
                        w_boss_n_out = 1'b0;
                        w_boss_n_oe  = 1'b1;
                        w_br_n_oe    = 1'b0;
                        w_dma_en     = 1'b1;
                        w_state      = ST_IDLE;
                    end else begin
                        w_br_n_oe = ~BG_n_IN;
                        w_dma_en  = BG_n_IN;
                        w_state   = BG_n_IN ? ST_IDLE : ST_DISABLED;
                    end
                end
            end

            ST_DISABLED: begin
                w_gnt_n = '1;
            end

            ST_IDLE: begin
                if (~&REQ_n) begin
                    w_sel      = w_win;
                    w_br_cpu_n = 1'b0;
                    w_state    = ST_REQUEST;
                end
            end

            ST_REQUEST: begin
                // A withdrawn request takes priority over a grant that
                // becomes possible in the same cycle.
                if (!w_sel_req) begin
                    w_br_cpu_n = 1'b1;
                    w_state    = ST_IDLE;
                end else if (!BG_CPU_n && AS_n && (&ACK_n)) begin
                    w_gnt_n  = ~w_sel_mask;
                    w_wd_cnt = 8'd0;
                    w_state  = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (w_sel_ack) begin
                    w_gnt_n       = '1;
                    w_bgack_cpu_n = 1'b0;
                    w_br_cpu_n    = 1'b1;
                    w_owner       = r_sel;
                    w_state       = ST_OWNED;
                    if (ROUND_ROBIN != 0) w_rr = w_sel_plus1;
                end else if (r_wd_cnt == c_ack_last) begin
                    w_gnt_n    = '1;
                    w_br_cpu_n = 1'b1;
                    w_timeout  = 1'b1;
                    w_state    = ST_IDLE;
                    if (ROUND_ROBIN != 0) w_rr = w_sel_plus1;
                end else begin
                    w_wd_cnt = r_wd_cnt + 8'd1;
                end
            end

            ST_OWNED: begin
                if (!w_sel_ack) begin
                    w_bgack_cpu_n = 1'b1;
                    w_rr          = w_sel_plus1;
                    w_state       = ST_IDLE;
                end
            end

            default: begin
                w_state = ST_BOOT_WAIT;
            end
        endcase
    end

    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state     <= ST_BOOT_WAIT;
            r_boot_cnt  <= 8'd0;
            r_wd_cnt    <= 8'd0;
            r_sel       <= 3'd0;
            r_rr        <= 3'd0;
            BR_CPU_n    <= 1'b0;
            BGACK_CPU_n <= 1'b1;
            GNT_n       <= '1;
            BOSS_n_OUT  <= 1'b1;
            BOSS_n_OE   <= 1'b0;
            BR_n_OE     <= 1'b1;
            E_OE        <= 1'b0;
            DMA_EN      <= 1'b0;
            OWNER       <= 3'd0;
            TIMEOUT     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_boot_cnt  <= w_boot_cnt;
            r_wd_cnt    <= w_wd_cnt;
            r_sel       <= w_sel;
            r_rr        <= w_rr;
            BR_CPU_n    <= w_br_cpu_n;
            BGACK_CPU_n <= w_bgack_cpu_n;
            GNT_n       <= w_gnt_n;
            BOSS_n_OUT  <= w_boss_n_out;
            BOSS_n_OE   <= w_boss_n_oe;
            BR_n_OE     <= w_br_n_oe;
            E_OE        <= w_e_oe;
            DMA_EN      <= w_dma_en;
            OWNER       <= w_owner;
            TIMEOUT     <= w_timeout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter_multi
// Purpose  : Directed self-checking bench for bus_arbiter_multi. It drives
//            two instances:
//              - a fixed-priority instance;
//              - a round-robin instance.
//            Both have NUM_REQ=2, BOOT_CYCLES=4 and ACK_TIMEOUT=16.
//            Request and acknowledge lines are steered to one instance at a
//            time, selected by use_rr.
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_arbiter_multi;

    logic       clk;
    logic       rst_n;
    logic       jp2;
    logic       boss_in;
    logic       bg_n_in;
    logic [1:0] req_n;
    logic [1:0] ack_n;
    logic       as_n;
    logic       bg_cpu_n;
    logic       use_rr;

    int n_pass   = 0;
    int n_checks = 0;

    logic [1:0] req_f, ack_f, req_r, ack_r;
    assign req_f = use_rr ? 2'b11 : req_n;
    assign ack_f = use_rr ? 2'b11 : ack_n;
    assign req_r = use_rr ? req_n : 2'b11;
    assign ack_r = use_rr ? ack_n : 2'b11;

    logic       br_f, bgack_f, boss_out_f, boss_oe_f, br_n_oe_f, e_oe_f, dma_f, timeout_f;
    logic [1:0] gnt_f;
    logic [2:0] owner_f;
    logic       br_r, bgack_r, boss_out_r, boss_oe_r, br_n_oe_r, e_oe_r, dma_r, timeout_r;
    logic [1:0] gnt_r;
    logic [2:0] owner_r;

    logic [1:0] gnt_obs;
    logic [2:0] owner_obs;
    assign gnt_obs   = use_rr ? gnt_r : gnt_f;
    assign owner_obs = use_rr ? owner_r : owner_f;

    bus_arbiter_multi #(
        .NUM_REQ(2), .BOOT_CYCLES(4), .ACK_TIMEOUT(16), .ROUND_ROBIN(0)
    ) dut (
        .C7M(clk), .RESET_n(rst_n), .JP2(jp2), .BOSS_n_IN(boss_in), .BG_n_IN(bg_n_in),
        .REQ_n(req_f), .ACK_n(ack_f), .AS_n(as_n), .BG_CPU_n(bg_cpu_n),
        .BR_CPU_n(br_f), .BGACK_CPU_n(bgack_f), .GNT_n(gnt_f),
        .BOSS_n_OUT(boss_out_f), .BOSS_n_OE(boss_oe_f), .BR_n_OE(br_n_oe_f), .E_OE(e_oe_f),
        .DMA_EN(dma_f), .OWNER(owner_f), .TIMEOUT(timeout_f)
    );

    bus_arbiter_multi #(
        .NUM_REQ(2), .BOOT_CYCLES(4), .ACK_TIMEOUT(16), .ROUND_ROBIN(1)
    ) dut_rr (
        .C7M(clk), .RESET_n(rst_n), .JP2(jp2), .BOSS_n_IN(boss_in), .BG_n_IN(bg_n_in),
        .REQ_n(req_r), .ACK_n(ack_r), .AS_n(as_n), .BG_CPU_n(bg_cpu_n),
        .BR_CPU_n(br_r), .BGACK_CPU_n(bgack_r), .GNT_n(gnt_r),
        .BOSS_n_OUT(boss_out_r), .BOSS_n_OE(boss_oe_r), .BR_n_OE(br_n_oe_r), .E_OE(e_oe_r),
        .DMA_EN(dma_r), .OWNER(owner_r), .TIMEOUT(timeout_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else             n_pass++;
    endtask

    // Holds both REQ_n low and services four grants. Each grant is checked
    // against the expected owner sequence, packed 3 bits per slot.
    task automatic owner_seq(input logic rr, input logic [11:0] exp_seq);
        logic [2:0] exp_own;
        logic [1:0] exp_gnt;
        int         waited;
        use_rr   = rr;
        req_n    = 2'b00;
        bg_cpu_n = 1'b0;
        as_n     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_own = exp_seq[3*k +: 3];
            exp_gnt = (exp_own == 3'd0) ? 2'b10 : 2'b01;
            waited  = 0;
            while (gnt_obs == 2'b11 && waited < 20) begin
                tick();
                waited++;
            end
            check("seq_grant_seen", {31'd0, gnt_obs != 2'b11}, 32'd1);
            check("seq_gnt", {30'd0, gnt_obs}, {30'd0, exp_gnt});
            ack_n = gnt_obs[0] ? 2'b01 : 2'b10;
            tick();
            check("seq_owner", {29'd0, owner_obs}, {29'd0, exp_own});
            ack_n = 2'b11;
            tick();
        end
        req_n    = 2'b11;
        bg_cpu_n = 1'b1;
        repeat (3) tick();
        use_rr = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        jp2      = 1'b0;
        boss_in  = 1'b1;
        bg_n_in  = 1'b1;
        req_n    = 2'b11;
        ack_n    = 2'b11;
        as_n     = 1'b1;
        bg_cpu_n = 1'b1;
        use_rr   = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_br_cpu",   br_f, 0);
        check("rst_bgack",    bgack_f, 1);
        check("rst_gnt",      gnt_f, 2'b11);
        check("rst_boss_out", boss_out_f, 1);
        check("rst_boss_oe",  boss_oe_f, 0);
        check("rst_br_n_oe",  br_n_oe_f, 1);
        check("rst_e_oe",     e_oe_f, 0);
        check("rst_dma_en",   dma_f, 0);
        check("rst_owner",    owner_f, 0);
        check("rst_timeout",  timeout_f, 0);

        // B2000 probe: the result appears BOOT_CYCLES+1 edges after release
        rst_n = 1'b1;
        repeat (4) tick();
        check("boot_br_held", br_f, 0);
        check("boot_dma_off", dma_f, 0);
        tick();
        check("b2k_boss_out", boss_out_f, 0);
        check("b2k_boss_oe",  boss_oe_f, 1);
        check("b2k_br_n_oe",  br_n_oe_f, 0);
        check("b2k_e_oe",     e_oe_f, 1);
        check("b2k_dma_en",   dma_f, 1);
        check("b2k_br_cpu",   br_f, 1);

        // Full handshake on requester 1
        req_n = 2'b01;
        tick();
        check("hs_br_cpu", br_f, 0);
        check("hs_no_gnt", gnt_f, 2'b11);
        bg_cpu_n = 1'b0;
        tick();
        check("hs_gnt1", gnt_f, 2'b01);
        ack_n    = 2'b01;
        bg_cpu_n = 1'b1;
        tick();
        check("hs_gnt_drop", gnt_f, 2'b11);
        check("hs_bgack",    bgack_f, 0);
        check("hs_owner",    owner_f, 1);
        check("hs_br_rel",   br_f, 1);
        ack_n = 2'b00;                        // a foreign ACK while owned is ignored
        tick();
        check("own_bgack_hold",  bgack_f, 0);
        check("own_foreign_ack", owner_f, 1);
        ack_n = 2'b11;
        req_n = 2'b11;
        tick();
        check("own_release", bgack_f, 1);

        // Grant blocked while AS_n is low
        req_n    = 2'b10;
        as_n     = 1'b0;
        bg_cpu_n = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("as_block_gnt", gnt_f, 2'b11);
        end
        as_n = 1'b1;
        tick();
        check("as_release_gnt", gnt_f, 2'b10);

        // Watchdog: grant outstanding for ACK_TIMEOUT cycles, then withdrawn
        for (int i = 0; i < 15; i++) begin
            tick();
            check("to_wait_gnt",   gnt_f, 2'b10);
            check("to_wait_pulse", timeout_f, 0);
        end
        tick();
        check("to_pulse",  timeout_f, 1);
        check("to_gnt",    gnt_f, 2'b11);
        check("to_br_rel", br_f, 1);
        tick();
        check("to_pulse_end", timeout_f, 0);
        check("re_request",   br_f, 0);
        req_n = 2'b11;                        // withdraw before grant
        tick();
        check("withdraw_br",  br_f, 1);
        check("withdraw_gnt", gnt_f, 2'b11);
        bg_cpu_n = 1'b1;
        tick();

        // Arbitration order: fixed always 0, rotating 0,1,0,1
        owner_seq(1'b0, 12'h000);
        owner_seq(1'b1, 12'h208);

        // Asynchronous reset returns outputs without a clock edge
        rst_n = 1'b0;
        #2;
        check("async_dma",     dma_f, 0);
        check("async_boss_oe", boss_oe_f, 0);
        check("async_br_cpu",  br_f, 0);

        // A500 with CPU fitted: stuck probing until the jumper reads 1
        boss_in = 1'b0;
        bg_n_in = 1'b0;
        jp2     = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("probe_stuck_br",  br_f, 0);
        check("probe_stuck_dma", dma_f, 0);
        jp2 = 1'b1;
        tick();
        check("a500_dma_en",  dma_f, 0);
        check("a500_br_n_oe", br_n_oe_f, 1);
        check("a500_e_oe",    e_oe_f, 0);
        check("a500_br_cpu",  br_f, 1);
        check("a500_boss_oe", boss_oe_f, 0);
        req_n    = 2'b10;
        bg_cpu_n = 1'b0;
        repeat (5) tick();
        check("dis_no_gnt", gnt_f, 2'b11);
        check("dis_br_cpu", br_f, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
`default_nettype wire
